// File: rtl/cd_sector_fetch_buffer.sv
// Ping-pong sector store: fetches one raw CD sector from HPS into a free bank
// and streams full banks to the CDIC over a valid/ready word interface.
module cd_sector_fetch_buffer #(
   parameter int WORDS  = 1176,
   parameter int ADDR_W = 11
) (
   input  logic        clk30,
   input  logic        reset,
   input  logic        fetch,
   input  logic [31:0] fetch_lba,
   input  logic        abort,
   output logic        fetch_accept,
   output logic        fetch_reject,
   output logic        busy,
   output logic        protocol_err,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] out_data,
   output logic        out_last,
   output logic [31:0] cd_hps_lba,
   output logic        cd_hps_req,
   input  logic        cd_hps_ack,
   input  logic        cd_hps_data_valid,
   input  logic [15:0] cd_hps_data
);

   localparam int DEPTH = 2 ** (ADDR_W + 1);
   localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(WORDS - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQUEST,
      S_RECEIVE
   } state_t;

   state_t state, state_nxt;

   logic              accept_nxt, reject_nxt;
   logic              wr_en, wr_done, stray;
   logic [ADDR_W-1:0] wr_ptr;
   logic              wr_bank;
   logic [1:0]        bank_full;

   logic [15:0]       mem [DEPTH];

   logic [ADDR_W-1:0] rd_ptr;
   logic              rd_bank;
   logic              rd_issued;
   logic              rd_issue;
   logic              rd_vld_p1;
   logic [15:0]       rd_data_p1;
   logic              rd_last_p1;

   logic [1:0]        fifo_cnt;
   logic [15:0]       q0_data, q1_data;
   logic              q0_last, q1_last;
   logic              pop, push, last_xfer;
   logic [2:0]        occ, lim;

   // ---------------- write side: HPS request / capture FSM ----------------
   always_comb begin
      state_nxt  = state;
      accept_nxt = 1'b0;
      reject_nxt = 1'b0;
      wr_en      = 1'b0;
      wr_done    = 1'b0;
      stray      = 1'b0;
      case (state)
         S_IDLE: begin
            stray = cd_hps_data_valid;
            if (fetch) begin
               if (!bank_full[wr_bank] && !abort) begin
                  accept_nxt = 1'b1;
                  state_nxt  = S_REQUEST;
               end else begin
                  reject_nxt = 1'b1;
               end
            end
         end
         S_REQUEST: begin
            stray      = cd_hps_data_valid;
            reject_nxt = fetch;
            if (cd_hps_ack) state_nxt = S_RECEIVE;
         end
         S_RECEIVE: begin
            reject_nxt = fetch;
            if (cd_hps_data_valid) begin
               wr_en = 1'b1;
               if (wr_ptr == LAST_PTR) begin
                  wr_done   = 1'b1;
                  state_nxt = S_IDLE;
               end
            end
         end
         default: state_nxt = S_IDLE;
      endcase
      if (abort) begin
         state_nxt = S_IDLE;
         wr_en     = 1'b0;
         wr_done   = 1'b0;
      end
   end

   always_ff @(posedge clk30) begin
      if (reset) begin
         state        <= S_IDLE;
         fetch_accept <= 1'b0;
         fetch_reject <= 1'b0;
         protocol_err <= 1'b0;
         cd_hps_lba   <= '0;
         wr_ptr       <= '0;
         wr_bank      <= 1'b0;
      end else begin
         state        <= state_nxt;
         fetch_accept <= accept_nxt;
         fetch_reject <= reject_nxt;
         if (stray) protocol_err <= 1'b1;
         if (accept_nxt) cd_hps_lba <= fetch_lba;
         if (abort) begin
            wr_ptr  <= '0;
            wr_bank <= 1'b0;
         end else if (state == S_REQUEST && cd_hps_ack) begin
            wr_ptr <= '0;
         end else if (wr_en) begin
            if (wr_done) begin
               wr_ptr  <= '0;
               wr_bank <= ~wr_bank;
            end else begin
               wr_ptr <= wr_ptr + ADDR_W'(1);
            end
         end
      end
   end

   assign busy       = (state != S_IDLE);
   assign cd_hps_req = (state == S_REQUEST);

   // A bank freed this cycle is still seen full by the fetch check above.
   always_ff @(posedge clk30) begin
      if (reset || abort) begin
         bank_full <= 2'b00;
      end else begin
         if (wr_done) bank_full[wr_bank] <= 1'b1;
         if (last_xfer) bank_full[rd_bank] <= 1'b0;
      end
   end

   // ---------------- p0: read issue, credit-limited by the skid buffer ----------------
   assign pop       = out_valid && out_ready;
   assign last_xfer = pop && q0_last;
   assign push      = rd_vld_p1;
   assign occ       = {1'b0, fifo_cnt} + {2'b00, rd_vld_p1};
   assign lim       = 3'd2 + {2'b00, pop};
   assign rd_issue  = bank_full[rd_bank] && !rd_issued && (occ < lim);

   always_ff @(posedge clk30) begin
      if (wr_en) mem[{wr_bank, wr_ptr}] <= cd_hps_data;
      if (rd_issue) begin
         rd_data_p1 <= mem[{rd_bank, rd_ptr}];
         rd_last_p1 <= (rd_ptr == LAST_PTR);
      end
   end

   always_ff @(posedge clk30) begin
      if (reset || abort) begin
         rd_ptr    <= '0;
         rd_bank   <= 1'b0;
         rd_issued <= 1'b0;
         rd_vld_p1 <= 1'b0;
         fifo_cnt  <= 2'd0;
      end else begin
         rd_vld_p1 <= rd_issue;
         if (rd_issue) begin
            if (rd_ptr == LAST_PTR) begin
               rd_ptr    <= '0;
               rd_issued <= 1'b1;
            end else begin
               rd_ptr <= rd_ptr + ADDR_W'(1);
            end
         end
         if (last_xfer) begin
            rd_issued <= 1'b0;
            rd_bank   <= ~rd_bank;
         end
         case ({push, pop})
            2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
            2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
            default: fifo_cnt <= fifo_cnt;
         endcase
      end
   end

   // ---------------- p2: two-entry skid buffer feeding the consumer ----------------
   always_ff @(posedge clk30) begin
      if (reset) begin
         q0_data <= '0;
         q1_data <= '0;
         q0_last <= 1'b0;
         q1_last <= 1'b0;
      end else begin
         case ({push, pop})
            2'b11: begin
               if (fifo_cnt == 2'd2) begin
                  q0_data <= q1_data;
                  q0_last <= q1_last;
                  q1_data <= rd_data_p1;
                  q1_last <= rd_last_p1;
               end else begin
                  q0_data <= rd_data_p1;
                  q0_last <= rd_last_p1;
               end
            end
            2'b01: begin
               q0_data <= q1_data;
               q0_last <= q1_last;
            end
            2'b10: begin
               if (fifo_cnt == 2'd0) begin
                  q0_data <= rd_data_p1;
                  q0_last <= rd_last_p1;
               end else begin
                  q1_data <= rd_data_p1;
                  q1_last <= rd_last_p1;
               end
            end
            default: ;
         endcase
      end
   end

   assign out_valid = (fifo_cnt != 2'd0);
   assign out_data  = q0_data;
   assign out_last  = out_valid && q0_last;

endmodule

// File: tb/tb_cd_sector_fetch_buffer.sv
// Scoreboard bench for cd_sector_fetch_buffer: expected words are queued as HPS
// delivers them; a monitor pops and compares every word the consumer accepts.
module tb_cd_sector_fetch_buffer;

   localparam int WORDS = 1176;

   logic        clk30 = 1'b0;
   logic        reset;
   logic        fetch;
   logic [31:0] fetch_lba;
   logic        abort;
   logic        fetch_accept, fetch_reject, busy, protocol_err;
   logic        out_valid, out_ready, out_last;
   logic [15:0] out_data;
   logic [31:0] cd_hps_lba;
   logic        cd_hps_req, cd_hps_ack, cd_hps_data_valid;
   logic [15:0] cd_hps_data;

   cd_sector_fetch_buffer #(.WORDS(WORDS), .ADDR_W(11)) dut (
      .clk30(clk30), .reset(reset), .fetch(fetch), .fetch_lba(fetch_lba), .abort(abort),
      .fetch_accept(fetch_accept), .fetch_reject(fetch_reject), .busy(busy),
      .protocol_err(protocol_err), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_last(out_last), .cd_hps_lba(cd_hps_lba),
      .cd_hps_req(cd_hps_req), .cd_hps_ack(cd_hps_ack),
      .cd_hps_data_valid(cd_hps_data_valid), .cd_hps_data(cd_hps_data)
   );

   always #5 clk30 = ~clk30;

   int n_pass  = 0;
   int n_total = 0;
   int word_cnt = 0;
   int rdy_mode = 0;   // 0: hold low, 1: hold high, 2: toggle each cycle
   logic [16:0] exp_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   task automatic tick();
      @(posedge clk30);
      #1;
   endtask

   initial begin
      out_ready = 1'b0;
      forever begin
         @(posedge clk30);
         #1;
         case (rdy_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = ~out_ready;
         endcase
      end
   end

   // Monitor: compares every accepted word and checks hold-stability while stalled.
   logic        prev_stall = 1'b0;
   logic [16:0] prev_word;
   initial begin
      forever begin
         @(negedge clk30);
         if (reset) begin
            prev_stall = 1'b0;
         end else begin
            if (prev_stall) chk("stall_hold", {out_valid, out_last, out_data}, {1'b1, prev_word});
            if (out_valid && out_ready) begin
               word_cnt++;
               if (exp_q.size() == 0) begin
                  chk("unexpected_word", {out_last, out_data}, 32'h1_FFFF);
               end else begin
                  logic [16:0] e;
                  e = exp_q.pop_front();
                  chk("out_word", {out_last, out_data}, e);
               end
            end
            prev_stall = out_valid && !out_ready;
            prev_word  = {out_last, out_data};
         end
      end
   end

   task automatic do_fetch(input logic [31:0] lba, input logic exp_acc);
      fetch = 1'b1;
      fetch_lba = lba;
      tick();
      fetch = 1'b0;
      chk("fetch_accept", fetch_accept, exp_acc);
      chk("fetch_reject", fetch_reject, !exp_acc);
      if (exp_acc) chk("hps_lba", cd_hps_lba, lba);
   endtask

   task automatic do_ack(input int delay);
      repeat (delay) begin
         chk("req_high", cd_hps_req, 1'b1);
         tick();
      end
      cd_hps_ack = 1'b1;
      tick();
      cd_hps_ack = 1'b0;
      chk("req_low_after_ack", cd_hps_req, 1'b0);
   endtask

   task automatic send_words(input logic [15:0] base, input int n, input bit expect_out);
      for (int i = 0; i < n; i++) begin
         cd_hps_data_valid = 1'b1;
         cd_hps_data = base + 16'(i);
         if (expect_out) exp_q.push_back({(i == WORDS - 1), base + 16'(i)});
         tick();
      end
      cd_hps_data_valid = 1'b0;
   endtask

   task automatic fetch_sector(input logic [31:0] lba, input logic [15:0] base);
      do_fetch(lba, 1'b1);
      do_ack(2);
      send_words(base, WORDS, 1'b1);
   endtask

   task automatic wait_drain(input string name);
      int c = 0;
      while (exp_q.size() > 0 && c < 6000) begin
         tick();
         c++;
      end
      chk(name, exp_q.size(), 0);
      repeat (4) tick();
      chk({name, "_idle"}, out_valid, 1'b0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; fetch = 1'b0; fetch_lba = '0; abort = 1'b0;
      cd_hps_ack = 1'b0; cd_hps_data_valid = 1'b0; cd_hps_data = '0;
      repeat (3) tick();
      reset = 1'b0;
      tick();
      chk("rst_outputs", {fetch_accept, fetch_reject, busy, protocol_err, out_valid,
                          out_last, cd_hps_req}, 7'd0);
      chk("rst_data", {out_data, 16'h0}, 32'h0);
      chk("rst_lba", cd_hps_lba, 32'h0);

      // Basic transfer
      rdy_mode = 1;
      do_fetch(32'h1234, 1'b1);
      chk("busy_req", busy, 1'b1);
      do_ack(5);
      send_words(16'h0000, WORDS, 1'b1);
      chk("vld_lat0", out_valid, 1'b0);
      tick();
      chk("vld_lat1", out_valid, 1'b0);
      tick();
      chk("vld_lat2", out_valid, 1'b1);
      wait_drain("basic_drain");
      chk("basic_perr", protocol_err, 1'b0);

      // Bank exhaustion
      rdy_mode = 0;
      fetch_sector(32'h10, 16'h1000);
      fetch_sector(32'h11, 16'h2000);
      do_fetch(32'h12, 1'b0);
      chk("stall_head", {out_valid, out_last, out_data}, {2'b10, 16'h1000});
      rdy_mode = 1;
      begin
         int c = 0;
         while (exp_q.size() > WORDS && c < 3000) begin
            tick();
            c++;
         end
      end
      do_fetch(32'h13, 1'b1);
      do_ack(1);
      send_words(16'h3000, WORDS, 1'b1);
      wait_drain("exhaust_drain");

      // Back-pressure over two sectors
      rdy_mode = 2;
      word_cnt = 0;
      fetch_sector(32'h20, 16'h4000);
      fetch_sector(32'h21, 16'h5000);
      wait_drain("bp_drain");
      chk("bp_count", word_cnt, 2 * WORDS);

      // Stray HPS word in IDLE
      rdy_mode = 1;
      cd_hps_data_valid = 1'b1;
      cd_hps_data = 16'hDEAD;
      tick();
      cd_hps_data_valid = 1'b0;
      chk("stray_perr", protocol_err, 1'b1);
      repeat (3) tick();
      chk("stray_novalid", out_valid, 1'b0);
      fetch_sector(32'h30, 16'h6000);
      wait_drain("stray_drain");
      chk("stray_perr_sticky", protocol_err, 1'b1);

      // Reset after 500 words
      do_fetch(32'h40, 1'b1);
      do_ack(1);
      send_words(16'h9000, 500, 1'b0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("midrst_state", {cd_hps_req, busy, out_valid, protocol_err}, 4'b0000);
      cd_hps_data_valid = 1'b1;
      tick();
      cd_hps_data_valid = 1'b0;
      chk("midrst_stray_perr", protocol_err, 1'b1);
      fetch_sector(32'h41, 16'h7000);
      wait_drain("midrst_drain");

      // Abort in REQUEST, then a late ack
      do_fetch(32'h50, 1'b1);
      tick();
      chk("abort_req_before", cd_hps_req, 1'b1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort_req_busy", {cd_hps_req, busy}, 2'b00);
      cd_hps_ack = 1'b1;
      tick();
      cd_hps_ack = 1'b0;
      tick();
      chk("late_ack_ignored", {cd_hps_req, busy}, 2'b00);
      fetch_sector(32'h51, 16'h8000);
      wait_drain("abort_drain");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
